// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_pkg;

   typedef enum logic [1:0] {
      MD_MULTU = 2'd0,
      MD_DIVU  = 2'd1,
      MD_MULT  = 2'd2,
      MD_DIV   = 2'd3
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// Magnitude extraction of signed operands and sign correction of the raw
// unsigned result (2*WIDTH negate for products, separate quotient/remainder).
module mul_div_sign_fix
   import mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             op_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] mag_a,
   output logic [WIDTH-1:0] mag_b,
   output logic             neg_a,
   output logic             neg_b,
   input  logic             is_div,
   input  logic             neg_quo,
   input  logic             neg_rem,
   input  logic [WIDTH-1:0] raw_hi,
   input  logic [WIDTH-1:0] raw_lo,
   output logic [WIDTH-1:0] fix_hi,
   output logic [WIDTH-1:0] fix_lo
);

   logic [2*WIDTH-1:0] prod;

   always_comb begin
      neg_a = op_signed & a[WIDTH-1];
      neg_b = op_signed & b[WIDTH-1];
      mag_a = neg_a ? -a : a;
      mag_b = neg_b ? -b : b;
   end

   // neg_quo doubles as the product sign for multiplies
   always_comb begin
      prod   = {raw_hi, raw_lo};
      fix_hi = raw_hi;
      fix_lo = raw_lo;
      if (is_div) begin
         if (neg_quo) fix_lo = -raw_lo;
         if (neg_rem) fix_hi = -raw_hi;
      end else if (neg_quo) begin
         prod   = -prod;
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers, WIDTH edges per op.
// Signed MULT/DIV are built only when MUL_DIV_SIGNED_EN is defined.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   input  logic             WriteHI,
   input  logic             WriteLO,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = cnt_width(WIDTH);

   md_state_e          state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   opnd_b;
   logic               is_div;
   logic               start_ok, last_iter, dbz;
   logic               op_div;
   logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo;
   logic [WIDTH:0]     add_sum, rem_try;
   logic [WIDTH-1:0]   rem_sub;

   assign op_div = (Op == MD_DIVU) || (Op == MD_DIV);

`ifdef MUL_DIV_SIGNED_EN
   logic op_signed, neg_a, neg_b, neg_quo, neg_rem;

   assign op_signed = (Op == MD_MULT) || (Op == MD_DIV);

   mul_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .op_signed (op_signed),
      .a         (Operand1),
      .b         (Operand2),
      .mag_a     (mag_a),
      .mag_b     (mag_b),
      .neg_a     (neg_a),
      .neg_b     (neg_b),
      .is_div    (is_div),
      .neg_quo   (neg_quo),
      .neg_rem   (neg_rem),
      .raw_hi    (acc_nxt[2*WIDTH-1:WIDTH]),
      .raw_lo    (acc_nxt[WIDTH-1:0]),
      .fix_hi    (res_hi),
      .fix_lo    (res_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
      end else if (start_ok) begin
         neg_quo <= neg_a ^ neg_b;
         neg_rem <= neg_a;
      end
   end
`else
   logic unused_op_hi;

   assign unused_op_hi = Op[1];
   assign mag_a        = Operand1;
   assign mag_b        = Operand2;
   assign res_hi       = acc_nxt[2*WIDTH-1:WIDTH];
   assign res_lo       = acc_nxt[WIDTH-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN:     if (last_iter) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy      = (state == RUN);
      start_ok  = (state == IDLE) && Start;
      last_iter = (state == RUN) && (cnt == CW'(WIDTH - 1));
   end

   // acc = {partial product, multiplier} or {remainder, dividend/quotient}.
   // With a zero divisor the restoring loop leaves the dividend as remainder.
   always_comb begin
      add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
      rem_try = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      rem_sub = rem_try[WIDTH-1:0] - opnd_b;
      if (is_div) begin
         if (rem_try >= {1'b0, opnd_b}) acc_nxt = {rem_sub, acc[WIDTH-2:0], 1'b1};
         else                           acc_nxt = {rem_try[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = {add_sum, acc[WIDTH-1:1]};
      end
      dbz = is_div && (opnd_b == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         opnd_b    <= '0;
         is_div    <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         HI        <= '0;
         LO        <= '0;
      end else begin
         Done <= 1'b0;
         if (start_ok) begin
            cnt       <= '0;
            acc       <= op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opnd_b    <= op_div ? mag_b : mag_a;
            is_div    <= op_div;
            DivByZero <= 1'b0;
         end else if (Busy) begin
            cnt <= cnt + CW'(1);
            acc <= acc_nxt;
            if (last_iter) begin
               HI        <= res_hi;
               LO        <= dbz ? '1 : res_lo;
               Done      <= 1'b1;
               DivByZero <= dbz;
            end
         end
         if (!Busy) begin
            if (WriteHI) HI <= WriteData;
            if (WriteLO) LO <= WriteData;
         end
      end
   end

endmodule
